// File: rtl/store_data_packer_if.sv
// rtl/store_data_packer_if.sv - store request and memory write-beat bundle for store_data_packer
//
// Purpose: groups the store-request handshake, the data-memory write-port
// handshake and the status pulses of store_data_packer into one bundle.
// Ports/signals:
//   req_valid/req_ready                 store request handshake
//   req_addr/req_data/req_size          byte address, rs2 value, size (00 SB, 01 SH, 10 SW, 11 illegal)
//   mem_valid/mem_ready                 memory write beat handshake
//   mem_addr/mem_wdata/mem_be           word-aligned beat address, lane-positioned data, byte enables
//   done/misalign/err                   one-cycle status pulses
// Modports:
//   master  environment side (issues requests, acts as the memory)
//   slave   packer side
interface store_data_packer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic [1:0]            req_size;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_be;
    logic                  done;
    logic                  misalign;
    logic                  err;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, misalign, err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, misalign, err
    );
endinterface

// File: rtl/store_data_packer.sv
// rtl/store_data_packer.sv - MEM-stage store narrowing, lane placement and word-boundary split
//
// Purpose: narrows a register value to byte/half/word, shifts it onto the
// addressed byte lanes with matching byte enables, and splits stores that
// cross a word boundary into two aligned memory beats.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   store_data_packer_if.slave (request handshake, memory write port,
//         done/misalign/err pulses)
module store_data_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    store_data_packer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Control strobes from the FSM
    logic load0;
    logic load1;
    logic finish;
    logic raise_err;

    // Lane computation on the incoming request
    logic [1:0]              off;
    logic [3:0]              mask;
    logic [7:0]              be8;
    logic [DATA_WIDTH-1:0]   trunc;
    logic [2*DATA_WIDTH-1:0] d64;
    logic [ADDR_WIDTH-1:0]   addr0;
    logic [ADDR_WIDTH-1:0]   addr1;
    logic                    split_now;
    logic                    size_ok;

    // Registered beat fields; beat1 is captured at accept and swapped in later
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            be_q;
    logic [ADDR_WIDTH-1:0] b1_addr_q;
    logic [DATA_WIDTH-1:0] b1_wdata_q;
    logic [3:0]            b1_be_q;
    logic                  split_q;
    logic                  done_q;
    logic                  misalign_q;
    logic                  err_q;

    assign off     = bus.req_addr[1:0];
    assign size_ok = (bus.req_size != 2'b11);

    always_comb begin
        mask  = 4'b0000;
        trunc = '0;
        case (bus.req_size)
            2'b00: begin
                mask  = 4'b0001;
                trunc = {{(DATA_WIDTH-8){1'b0}}, bus.req_data[7:0]};
            end
            2'b01: begin
                mask  = 4'b0011;
                trunc = {{(DATA_WIDTH-16){1'b0}}, bus.req_data[15:0]};
            end
            2'b10: begin
                mask  = 4'b1111;
                trunc = bus.req_data;
            end
            default: begin
                mask  = 4'b0000;
                trunc = '0;
            end
        endcase
    end

    // Shifting across a double-width window lets the spill-over into the
    // next word fall out naturally as the upper half.
    assign be8       = {4'b0000, mask} << off;
    assign d64       = {{DATA_WIDTH{1'b0}}, trunc} << {off, 3'b000};
    assign split_now = |be8[7:4];
    assign addr0     = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign addr1     = addr0 + ADDR_WIDTH'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load0      = 1'b0;
        load1      = 1'b0;
        finish     = 1'b0;
        raise_err  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (size_ok) begin
                        state_next = BEAT0;
                        load0      = 1'b1;
                    end else begin
                        raise_err  = 1'b1;
                    end
                end
            end
            BEAT0: begin
                if (bus.mem_ready) begin
                    if (split_q) begin
                        state_next = BEAT1;
                        load1      = 1'b1;
                    end else begin
                        state_next = IDLE;
                        finish     = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (bus.mem_ready) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= 4'b0000;
            b1_addr_q  <= '0;
            b1_wdata_q <= '0;
            b1_be_q    <= 4'b0000;
            split_q    <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q     <= finish;
            err_q      <= raise_err;
            misalign_q <= load0 && split_now;
            if (load0) begin
                addr_q     <= addr0;
                wdata_q    <= d64[DATA_WIDTH-1:0];
                be_q       <= be8[3:0];
                b1_addr_q  <= addr1;
                b1_wdata_q <= d64[2*DATA_WIDTH-1:DATA_WIDTH];
                b1_be_q    <= be8[7:4];
                split_q    <= split_now;
            end else if (load1) begin
                addr_q  <= b1_addr_q;
                wdata_q <= b1_wdata_q;
                be_q    <= b1_be_q;
            end else if (finish) begin
                // Idle bus shows no enabled lanes and no stale data
                addr_q  <= '0;
                wdata_q <= '0;
                be_q    <= 4'b0000;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_valid = (state == BEAT0) || (state == BEAT1);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.done      = done_q;
    assign bus.misalign  = misalign_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_store_data_packer.sv
// tb/tb_store_data_packer.sv - directed self-checking bench for store_data_packer
module tb_store_data_packer;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    store_data_packer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    store_data_packer #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic req(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_size  = size;
    endtask

    task automatic beat(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
        chk({tag, "_valid"}, {31'b0, bus.mem_valid}, 32'd1);
        chk({tag, "_addr"},  bus.mem_addr, addr);
        chk({tag, "_wdata"}, bus.mem_wdata, wdata);
        chk({tag, "_be"},    {28'b0, bus.mem_be}, {28'b0, be});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_size  = 2'b00;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid",    {31'b0, bus.mem_valid}, 32'd0);
        chk("rst_ready",    {31'b0, bus.req_ready}, 32'd1);
        chk("rst_addr",     bus.mem_addr, 32'h0);
        chk("rst_wdata",    bus.mem_wdata, 32'h0);
        chk("rst_be",       {28'b0, bus.mem_be}, 32'h0);
        chk("rst_done",     {31'b0, bus.done}, 32'd0);
        chk("rst_misalign", {31'b0, bus.misalign}, 32'd0);
        chk("rst_err",      {31'b0, bus.err}, 32'd0);

        // SB at byte 3 of a word
        bus.mem_ready = 1'b1;
        req(32'h0000_1003, 32'hDEAD_BEEF, 2'b00);
        tick();
        bus.req_valid = 1'b0;
        beat("sb", 32'h0000_1000, 32'hEF00_0000, 4'b1000);
        chk("sb_misalign", {31'b0, bus.misalign}, 32'd0);
        chk("sb_ready_busy", {31'b0, bus.req_ready}, 32'd0);
        tick();
        chk("sb_done",  {31'b0, bus.done}, 32'd1);
        chk("sb_idle",  {31'b0, bus.mem_valid}, 32'd0);
        chk("sb_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("sb_be_idle", {28'b0, bus.mem_be}, 32'h0);
        tick();
        chk("sb_done_once", {31'b0, bus.done}, 32'd0);

        // SW stalled by memory for 3 cycles; a request during the stall is ignored
        bus.mem_ready = 1'b0;
        req(32'h0000_2000, 32'h1234_5678, 2'b10);
        tick();
        req(32'h0000_0000, 32'h0, 2'b11);
        for (int i = 0; i < 3; i++) begin
            beat("sw_stall", 32'h0000_2000, 32'h1234_5678, 4'b1111);
            chk("sw_stall_ready", {31'b0, bus.req_ready}, 32'd0);
            chk("sw_stall_done",  {31'b0, bus.done}, 32'd0);
            tick();
            chk("sw_stall_err", {31'b0, bus.err}, 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        beat("sw_last", 32'h0000_2000, 32'h1234_5678, 4'b1111);
        chk("sw_last_ready", {31'b0, bus.req_ready}, 32'd0);
        tick();
        chk("sw_done",  {31'b0, bus.done}, 32'd1);
        chk("sw_idle",  {31'b0, bus.mem_valid}, 32'd0);
        tick();

        // SH crossing a word boundary
        req(32'h0000_3003, 32'hFFFF_ABCD, 2'b01);
        tick();
        bus.req_valid = 1'b0;
        chk("sh_misalign", {31'b0, bus.misalign}, 32'd1);
        beat("sh_b0", 32'h0000_3000, 32'hCD00_0000, 4'b1000);
        tick();
        chk("sh_misalign_once", {31'b0, bus.misalign}, 32'd0);
        chk("sh_b1_done", {31'b0, bus.done}, 32'd0);
        beat("sh_b1", 32'h0000_3004, 32'h0000_00AB, 4'b0001);
        tick();
        chk("sh_done", {31'b0, bus.done}, 32'd1);
        chk("sh_idle", {31'b0, bus.mem_valid}, 32'd0);
        tick();
        chk("sh_done_once", {31'b0, bus.done}, 32'd0);

        // SW crossing the top of the address space
        req(32'hFFFF_FFFE, 32'h1122_3344, 2'b10);
        tick();
        bus.req_valid = 1'b0;
        chk("wrap_misalign", {31'b0, bus.misalign}, 32'd1);
        beat("wrap_b0", 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
        tick();
        beat("wrap_b1", 32'h0000_0000, 32'h0000_1122, 4'b0011);
        tick();
        chk("wrap_done", {31'b0, bus.done}, 32'd1);
        tick();

        // Illegal size, then a legal SB the following cycle
        req(32'h0000_0000, 32'hFFFF_FFFF, 2'b11);
        tick();
        chk("ill_err",   {31'b0, bus.err}, 32'd1);
        chk("ill_valid", {31'b0, bus.mem_valid}, 32'd0);
        chk("ill_done",  {31'b0, bus.done}, 32'd0);
        chk("ill_ready", {31'b0, bus.req_ready}, 32'd1);
        req(32'h0000_0005, 32'h0000_00A5, 2'b00);
        tick();
        bus.req_valid = 1'b0;
        chk("ill_err_once", {31'b0, bus.err}, 32'd0);
        beat("post_sb", 32'h0000_0004, 32'h0000_A500, 4'b0010);
        tick();
        chk("post_sb_done", {31'b0, bus.done}, 32'd1);
        tick();

        // Reset while beat1 is stalled
        bus.mem_ready = 1'b0;
        req(32'h0000_3003, 32'hFFFF_ABCD, 2'b01);
        tick();
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        beat("stall_b1", 32'h0000_3004, 32'h0000_00AB, 4'b0001);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {31'b0, bus.mem_valid}, 32'd0);
        chk("mid_rst_be",    {28'b0, bus.mem_be}, 32'h0);
        chk("mid_rst_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("mid_rst_done",  {31'b0, bus.done}, 32'd0);
        bus.mem_ready = 1'b1;
        tick();
        chk("mid_rst_no_done", {31'b0, bus.done}, 32'd0);
        chk("mid_rst_still_idle", {31'b0, bus.mem_valid}, 32'd0);

        req(32'h0000_0010, 32'hCAFE_F00D, 2'b10);
        tick();
        bus.req_valid = 1'b0;
        beat("after_rst", 32'h0000_0010, 32'hCAFE_F00D, 4'b1111);
        chk("after_rst_misalign", {31'b0, bus.misalign}, 32'd0);
        tick();
        chk("after_rst_done", {31'b0, bus.done}, 32'd1);
        tick();
        chk("after_rst_done_once", {31'b0, bus.done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
